mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store initiator driving the word-wide dataMem port: aluOutAddr, writeData, memRead, memWrite, outData.
//  Accepts byte/half/word load and store requests from the CPU datapath.
//  Performs the byte-lane extract and sign-extend for loads.
//  Performs read-modify-write for sub-word stores, since dataMem only writes full words.
// PARAMETERS
//  MEM_RD_LAT  1  cycles memRead is held before outData is sampled (>=1; 1 = combinational-read dataMem)
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller idle; request accepted on req_valid&&req_ready at posedge
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00 byte, 01 half, 10/11 word
//  req_signed  in   1   loads only: 1 sign-extend, 0 zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   one-cycle completion pulse
//  resp_rdata  out  32  load result (0 for stores), valid with resp_valid
//  resp_err    out  1   misaligned request (MEM_ALIGN_CHECK_EN only; else tied 0)
//  aluOutAddr  out  32  memory address, always {addr[31:2],2'b00}
//  writeData   out  32  memory write word
//  memRead     out  1   memory read strobe
//  memWrite    out  1   memory write strobe
//  outData     in   32  memory read data
// BEHAVIOUR
//  - States: IDLE, RD_WAIT, WR, RESP. req_ready = (state==IDLE), combinational from state.
//  - Accept: all req_* fields latched; further req_* changes are ignored until return to IDLE.
//  - Load: IDLE->RD_WAIT. memRead=1 for exactly MEM_RD_LAT cycles; outData captured at last edge -> RESP.
//  - Word store: IDLE->WR. memWrite=1 one cycle, writeData=req_wdata -> RESP.
//  - Sub-word store: IDLE->RD_WAIT (capture old word) -> WR (merged word) -> RESP.
//    Only the addressed byte/half lane is replaced.
//  - RESP: resp_valid=1 for one cycle, then -> IDLE. resp_valid, resp_rdata, resp_err are registered.
//  - Latency from accept edge to resp_valid high: load MEM_RD_LAT+1; word store 2; sub-word store MEM_RD_LAT+2.
//    Back-to-back throughput: one request per (latency+1) cycles.
//  - Little-endian lanes. Byte lane = addr[1:0]. Half lane = addr[1] (low half when addr[1]=0).
//  - Load extract: selected lane shifted to bit 0, then extended per req_signed. Word loads pass through.
//  - memRead and memWrite never high in the same cycle. Both are 0 in IDLE and RESP.
//  - aluOutAddr/writeData hold last value outside strobes; only meaningful while a strobe is high.
//  - Reset (async, any state): state=IDLE, req_ready=1, all other outputs 0 immediately.
//    An in-flight RMW is abandoned before its write; memory is left unchanged.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - Half requests with addr[0]!=0, and word requests with addr[1:0]!=0, are misaligned.
//    - Misaligned: IDLE->RESP directly; no memRead/memWrite; resp_err=1, resp_rdata=0. Latency 1.
//  MEM_ALIGN_CHECK_EN undefined:
//    - No check; resp_err tied 0.
//    - Offending low address bits ignored: half uses addr[1], word uses the aligned word.
// TESTING (combinational-read dataMem model, MEM_RD_LAT=1)
//  1 sw addr=0x4 wdata=0x45 -> one memWrite cycle, aluOutAddr=0x4, writeData=0x45; resp_valid 2 cycles after accept; no memRead.
//  2 then lw addr=0x4 -> memRead one cycle at aluOutAddr=0x4; resp_rdata=0x00000045 1+1 cycles after accept.
//  3 word@0x4=0x11223344; sb addr=0x6 wdata=0xAB -> memRead then memWrite writeData=0x11AB3344; sh addr=0x4 wdata=0xBEEF -> 0x11ABBEEF.
//  4 word@0x4=0x80FF7F01; lb signed addr=0x7 -> 0xFFFFFF80; lbu addr=0x7 -> 0x00000080; lh signed addr=0x6 -> 0xFFFF80FF; lhu addr=0x4 -> 0x00007F01.
//  5 lw addr=0x6: with MEM_ALIGN_CHECK_EN -> resp_err=1, resp_rdata=0, no strobes, resp 1 cycle after accept; without -> returns word@0x4, resp_err=0.
//  6 sb addr=0x5 with rst pulsed during RD_WAIT -> memRead drops at once, memWrite never asserts, word@0x4 unchanged, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide data memory: byte-lane extract/extend on loads, read-modify-write for sub-word stores.
// Optional misalignment trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] aluOutAddr,
    output logic [31:0] writeData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] outData
);

    localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          we_q, signed_q, err_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, old_q;
    logic          resp_valid_q, resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic          accept, rd_last, misaligned;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data, merged;

    assign accept  = req_valid && req_ready;
    assign rd_last = (cnt_q == CW'(MEM_RD_LAT - 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; word stores skip the read, everything else reads first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_d = RESP;
                    else if (req_we && req_size[1])
                        state_d = WR;
                    else
                        state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_last)
                    state_d = we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == IDLE);
        memRead   = (state_q == RD_WAIT);
        memWrite  = (state_q == WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            old_q        <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= misaligned;
            end
            cnt_q <= (state_q == RD_WAIT && !rd_last) ? cnt_q + 1'b1 : '0;
            if (state_q == RD_WAIT && rd_last)
                old_q <= outData;
            resp_valid_q <= (state_q == RESP);
            resp_err_q   <= (state_q == RESP) && err_q;
            resp_rdata_q <= (state_q == RESP && !we_q && !err_q) ? load_data : 32'h0;
        end
    end

    // Load lane extract and extension
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = old_q[7:0];
            2'b01:   byte_sel = old_q[15:8];
            2'b10:   byte_sel = old_q[23:16];
            default: byte_sel = old_q[31:24];
        endcase
        half_sel = addr_q[1] ? old_q[31:16] : old_q[15:0];
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_data = old_q;
        endcase
    end

    // Sub-word store merge into the previously read word
    always_comb begin
        merged = old_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0]  = wdata_q[15:0];
        end
    end

    assign writeData  = size_q[1] ? wdata_q : merged;
    assign aluOutAddr = {addr_q[31:2], 2'b00};
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl against a combinational-read word memory.
module tb_mem_access_ctrl;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] aluOutAddr, writeData, outData;
    logic        memRead, memWrite;

    logic [31:0] mem [0:15];
    logic [31:0] exp_mem [0:15];
    logic        mem_clr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    mem_access_ctrl #(.MEM_RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .aluOutAddr (aluOutAddr),
        .writeData  (writeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .outData    (outData)
    );

    always #5 clk = ~clk;

    assign outData = mem[aluOutAddr[5:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (memWrite) begin
            mem[aluOutAddr[5:2]] <= writeData;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        if (sz == 2'b00)      mask = 32'hFF << (8 * a[1:0]);
        else if (sz == 2'b01) mask = 32'hFFFF << (16 * a[1]);
        else                  return d;
        return (w & ~mask) | ((d << (8 * a[1:0] & (sz == 2'b01 ? 16 : 24))) & mask);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit has_spec, input logic [31:0] spec_val);
        exp_t        e, got;
        logic        mis;
        logic [3:0]  idx;
        logic [31:0] nw, wd_seen;
        int          rd_exp, wr_exp, cyc, rdc, wrc, both;

        idx = a[5:2];
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
        nw = m_store(exp_mem[idx], sz, a, wd);
        if (mis) begin
            e.rdata = 32'h0; e.err = 1'b1; e.lat = 1; rd_exp = 0; wr_exp = 0;
        end else if (!we) begin
            e.rdata = m_load(exp_mem[idx], sz, sg, a); e.err = 1'b0; e.lat = LAT + 1;
            rd_exp = LAT; wr_exp = 0;
        end else if (sz[1]) begin
            e.rdata = 32'h0; e.err = 1'b0; e.lat = 2; rd_exp = 0; wr_exp = 1;
        end else begin
            e.rdata = 32'h0; e.err = 1'b0; e.lat = LAT + 2; rd_exp = LAT; wr_exp = 1;
        end
        sb.push_back(e);

        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_val("ready_wait", 32'(req_ready), 32'd1);

        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = $urandom_range(0, 1); req_size = 2'($urandom); req_signed = $urandom_range(0, 1);
        req_addr = $urandom; req_wdata = $urandom;

        cyc = 0; rdc = 0; wrc = 0; both = 0; wd_seen = 32'h0;
        while (!resp_valid && cyc < 20) begin
            if (memRead) begin
                rdc++;
                check_val("rd_addr", aluOutAddr, {a[31:2], 2'b00});
            end
            if (memWrite) begin
                wrc++;
                wd_seen = writeData;
                check_val("wr_addr", aluOutAddr, {a[31:2], 2'b00});
            end
            if (memRead && memWrite) both++;
            @(posedge clk); #1; cyc++;
        end

        got = sb.pop_front();
        check_val("latency", 32'(cyc), 32'(got.lat));
        check_val("rdata", resp_rdata, got.rdata);
        check_val("err", 32'(resp_err), 32'(got.err));
        check_val("rd_cycles", 32'(rdc), 32'(rd_exp));
        check_val("wr_cycles", 32'(wrc), 32'(wr_exp));
        check_val("rd_wr_overlap", 32'(both), 32'd0);
        check_val("ready_at_resp", 32'(req_ready), 32'd1);
        if (wr_exp != 0) check_val("wdata", wd_seen, nw);
        if (has_spec) check_val("spec_rdata", resp_rdata, spec_val);
        $display("txn we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, sz, sg, a, wd, resp_rdata, resp_err, cyc);

        @(posedge clk); #1;
        check_val("resp_pulse", 32'(resp_valid), 32'd0);
        if (we && !mis) exp_mem[idx] = nw;
        check_val("mem_word", mem[idx], exp_mem[idx]);
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check_val("rst_addr", aluOutAddr, 32'h0);
        check_val("rst_rdata", resp_rdata, 32'h0);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h45, 1'b1, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 32'h0000_0045);

        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, 1'b0, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'hAB, 1'b0, 32'h0);
        check_val("sb_merge", mem[1], 32'h11AB_3344);
        do_req(1'b1, 2'b01, 1'b0, 32'h4, 32'hBEEF, 1'b0, 32'h0);
        check_val("sh_merge", mem[1], 32'h11AB_BEEF);

        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h80FF_7F01, 1'b0, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 1'b1, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b1, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b1, 32'hFFFF_80FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 1'b1, 32'h0000_7F01);

`ifdef MEM_ALIGN_CHECK_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 32'h80FF_7F01);
`endif
        do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h1234, 1'b0, 32'h0);

        // Reset during the read phase of a byte store must abandon the write
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, 1'b0, 32'h0);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h5; req_wdata = 32'hEE;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("rmw_reading", 32'(memRead), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_rd_drop", 32'(memRead), 32'd0);
        check_val("rst_ready_now", 32'(req_ready), 32'd1);
        check_val("rst_no_resp", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            check_val("rst_no_write", 32'(memWrite), 32'd0);
            check_val("rst_no_resp_late", 32'(resp_valid), 32'd0);
        end
        check_val("rmw_abandoned", mem[1], 32'h1122_3344);
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 32'h1122_3344);

        for (int i = 0; i < 16; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
